// File: rtl/rprelu_para_loader.sv
`default_nettype none
// ============================================================================
// Module      : rprelu_para_loader
// Description : Streams beta, gamma, then zeta words for every channel into
//               the RPReLU parameter arrays and flags completion.
// Revision    : 1.0 - initial release
// ============================================================================
module rprelu_para_loader #(
    parameter int PARA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int CNT_WIDTH   = $clog2(CHANNEL_NUM)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         load_start,
    input  logic                         para_in_valid,
    input  logic signed [PARA_WIDTH-1:0] para_in,
    output logic                         para_in_ready,
    output logic signed [PARA_WIDTH-1:0] beta  [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] gamma [CHANNEL_NUM],
    output logic signed [PARA_WIDTH-1:0] zeta  [CHANNEL_NUM],
    output logic                         load_busy,
    output logic                         para_done
);

    localparam logic [CNT_WIDTH-1:0] C_LAST_CH = CNT_WIDTH'(CHANNEL_NUM - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_BETA  = 2'd1,
        LOAD_GAMMA = 2'd2,
        LOAD_ZETA  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_next_cnt;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_set_done;
    logic                 w_clr_done;

    assign para_in_ready = (r_state != IDLE);
    assign load_busy     = (r_state != IDLE);
    assign w_xfer        = para_in_valid & para_in_ready;
    assign w_last        = (r_cnt == C_LAST_CH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            para_done <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_clr_done)
                para_done <= 1'b0;
            else if (w_set_done)
                para_done <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_set_done   = 1'b0;
        w_clr_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_next_state = LOAD_BETA;
                    w_next_cnt   = '0;
                    w_clr_done   = 1'b1;
                end
            end
            default: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_next_cnt = '0;
                        case (r_state)
                            LOAD_BETA:  w_next_state = LOAD_GAMMA;
                            LOAD_GAMMA: w_next_state = LOAD_ZETA;
                            default: begin
                                w_next_state = IDLE;
                                w_set_done   = 1'b1;
                            end
                        endcase
                    end else begin
                        w_next_cnt = r_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // Words are stored verbatim; beta keeps its Q-format, gamma/zeta stay in the data domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                beta[i]  <= '0;
                gamma[i] <= '0;
                zeta[i]  <= '0;
            end
        end else if (w_xfer) begin
            case (r_state)
                LOAD_BETA:  beta[r_cnt]  <= para_in;
                LOAD_GAMMA: gamma[r_cnt] <= para_in;
                LOAD_ZETA:  zeta[r_cnt]  <= para_in;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rprelu_para_loader.sv
`default_nettype none
// Directed bench for rprelu_para_loader: full loads, bubbles, ignored inputs,
// negative reload and asynchronous reset in the middle of a load.
module tb_rprelu_para_loader;

    localparam int C_W  = 16;
    localparam int C_CH = 128;
    localparam int C_N  = 3 * C_CH;

    logic                  clk;
    logic                  rstn;
    logic                  load_start;
    logic                  para_in_valid;
    logic signed [C_W-1:0] para_in;
    logic                  para_in_ready;
    logic signed [C_W-1:0] beta  [C_CH];
    logic signed [C_W-1:0] gamma [C_CH];
    logic signed [C_W-1:0] zeta  [C_CH];
    logic                  load_busy;
    logic                  para_done;

    int n_checks = 0;
    int n_fail   = 0;

    rprelu_para_loader #(
        .PARA_WIDTH (C_W),
        .CHANNEL_NUM(C_CH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load_start   (load_start),
        .para_in_valid(para_in_valid),
        .para_in      (para_in),
        .para_in_ready(para_in_ready),
        .beta         (beta),
        .gamma        (gamma),
        .zeta         (zeta),
        .load_busy    (load_busy),
        .para_done    (para_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [C_W-1:0] word_of(input int mode, input int k);
        return (mode == 0) ? C_W'(k) : 16'hFF80;
    endfunction

    task automatic verify(input int mode, input string nm);
        for (int i = 0; i < C_CH; i++) begin
            chk($sformatf("%s_beta[%0d]", nm, i),  32'($unsigned(beta[i])),  32'(word_of(mode, i)));
            chk($sformatf("%s_gamma[%0d]", nm, i), 32'($unsigned(gamma[i])), 32'(word_of(mode, C_CH + i)));
            chk($sformatf("%s_zeta[%0d]", nm, i),  32'($unsigned(zeta[i])),  32'(word_of(mode, 2*C_CH + i)));
        end
    endtask

    task automatic verify_reset(input string nm);
        int nz = 0;
        for (int i = 0; i < C_CH; i++)
            if (beta[i] !== 0 || gamma[i] !== 0 || zeta[i] !== 0) nz++;
        chk({nm, "_nonzero_entries"}, nz, 0);
        chk({nm, "_done"},  32'(para_done),     0);
        chk({nm, "_ready"}, 32'(para_in_ready), 0);
        chk({nm, "_busy"},  32'(load_busy),     0);
    endtask

    // Runs one load; stops after stop_after transfers (C_N for a full load).
    task automatic run_load(input int mode, input bit bubble, input int pulse_at, input int stop_after);
        int n = 0;
        int cyc = 0;
        int busy_cnt;
        int diffs;
        bit x;
        logic [C_W-1:0] sb [C_CH];
        logic [C_W-1:0] sg [C_CH];
        logic [C_W-1:0] sz [C_CH];
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        busy_cnt = load_busy ? 1 : 0;
        chk("busy_after_start", 32'(load_busy), 1);
        chk("done_cleared", 32'(para_done), 0);
        while (n < stop_after && cyc < 4000) begin
            para_in_valid = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
            para_in       = word_of(mode, n);
            load_start    = (n == pulse_at);
            x = para_in_valid && para_in_ready;
            if (!para_in_valid)
                for (int i = 0; i < C_CH; i++) begin
                    sb[i] = beta[i]; sg[i] = gamma[i]; sz[i] = zeta[i];
                end
            @(posedge clk); #1;
            if (!para_in_valid) begin
                diffs = 0;
                for (int i = 0; i < C_CH; i++)
                    if (sb[i] !== beta[i] || sg[i] !== gamma[i] || sz[i] !== zeta[i]) diffs++;
                chk("stable_on_bubble", diffs, 0);
            end
            if (x) n++;
            cyc++;
            if (load_busy) busy_cnt++;
            if (x && n == C_N - 1) chk("done_before_last", 32'(para_done), 0);
        end
        para_in_valid = 1'b0;
        load_start    = 1'b0;
        chk("load_xfers", n, stop_after);
        if (stop_after == C_N) begin
            chk("done_after_load", 32'(para_done), 1);
            chk("busy_after_load", 32'(load_busy), 0);
            chk("ready_after_load", 32'(para_in_ready), 0);
            if (!bubble) chk("busy_cycles", busy_cnt, C_N);
        end
    endtask

    initial begin
        rstn = 1'b0; load_start = 1'b0; para_in_valid = 1'b0; para_in = '0;
        repeat (3) @(posedge clk);
        #1;
        verify_reset("por");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Words offered in IDLE must be ignored
        para_in_valid = 1'b1; para_in = 16'sh1234;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_ready", 32'(para_in_ready), 0);
        end
        chk("idle_beta0", 32'($unsigned(beta[0])), 0);
        para_in_valid = 1'b0;

        run_load(0, 1'b0, -1, C_N);
        verify(0, "full");

        // Extra word after completion is not accepted
        para_in_valid = 1'b1; para_in = 16'sh1234;
        @(posedge clk); #1;
        chk("post_ready", 32'(para_in_ready), 0);
        chk("post_zeta127", 32'($unsigned(zeta[C_CH-1])), 32'(C_N - 1));
        chk("post_beta0", 32'($unsigned(beta[0])), 0);
        para_in_valid = 1'b0;

        run_load(1, 1'b0, -1, C_N);
        verify(1, "neg");

        // Bubbles plus a stray load_start mid-load
        run_load(0, 1'b1, 50, C_N);
        verify(0, "bubble");

        // Async reset after 200 transfers
        run_load(0, 1'b0, -1, 200);
        chk("mid_gamma71", 32'($unsigned(gamma[71])), 32'(C_CH + 71));
        chk("mid_busy", 32'(load_busy), 1);
        #3 rstn = 1'b0;
        #1 verify_reset("async_rst");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        verify_reset("after_rst");

        run_load(0, 1'b0, -1, C_N);
        verify(0, "reload");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
